pll_lock_supervisor: RTL and testbench

- Consumes the PLL lock indication and sequences the PLL's reset input and the reset of all logic clocked by pll_clk.
- Runs on the free-running 27 MHz sys_clk, which is valid before the PLL locks.
- Holds downstream logic in reset until lock has been continuously stable, retries the PLL on lock timeout, counts lock-loss events, and flags a permanent fault after repeated failures.

---
 rtl/pll_lock_supervisor.sv | 145 ++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: sequences the PLL reset pin and the downstream core reset
// from a synchronized lock indication, with a lock timeout and retry limit, and a loss counter.
module pll_lock_supervisor #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 27000,
    parameter int unsigned STABLE_CYCLES = 2700,
    parameter int unsigned MAX_RETRIES   = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             pll_lock,
    output logic             pll_reset,
    output logic             core_rst,
    output logic             ready,
    output logic             fault,
    output logic [CNT_W-1:0] loss_count,
    output logic [2:0]       retry_count
);

    localparam int unsigned MAX_AB = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned MAX_T  = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
    localparam int unsigned CW     = (MAX_T > 1) ? $clog2(MAX_T) : 1;

    localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] ST_LAST  = CW'(STABLE_CYCLES - 1);
    localparam logic [2:0]    MAX_R    = 3'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAULT
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       sync_q, sync_d;
    logic [2:0]       retry_q, retry_d;
    logic [CNT_W-1:0] loss_q, loss_d;
    logic             pll_reset_q, pll_reset_d;
    logic             core_rst_q, core_rst_d;
    logic             ready_q, ready_d;
    logic             fault_q, fault_d;
    logic             lock_s;

    always_comb begin
        sync_d  = {sync_q[0], pll_lock};
        lock_s  = sync_q[1];
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        loss_d  = loss_q;

        case (state_q)
            S_RESET_PLL: begin
                if (cnt_q == RST_LAST) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = S_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TO_LAST) begin
                    retry_d = retry_q + 3'd1;
                    cnt_d   = '0;
                    state_d = (retry_d == MAX_R) ? S_FAULT : S_RESET_PLL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STABLE: begin
                if (!lock_s) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == ST_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    retry_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                // A loss leaves the PLL running and gives it a full timeout to relock.
                if (!lock_s) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                    if (loss_q != '1) begin
                        loss_d = loss_q + 1'b1;
                    end
                end
            end
            S_FAULT: ;
            default: begin
                state_d = S_RESET_PLL;
                cnt_d   = '0;
            end
        endcase

        // Outputs decode the next state so they switch on the same edge as the state.
        pll_reset_d = (state_d == S_RESET_PLL) || (state_d == S_FAULT);
        core_rst_d  = (state_d != S_RUN);
        ready_d     = (state_d == S_RUN);
        fault_d     = (state_d == S_FAULT);
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q     <= S_RESET_PLL;
            cnt_q       <= '0;
            sync_q      <= '0;
            retry_q     <= '0;
            loss_q      <= '0;
            pll_reset_q <= 1'b1;
            core_rst_q  <= 1'b1;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sync_q      <= sync_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
            pll_reset_q <= pll_reset_d;
            core_rst_q  <= core_rst_d;
            ready_q     <= ready_d;
            fault_q     <= fault_d;
        end
    end

    assign pll_reset   = pll_reset_q;
    assign core_rst    = core_rst_q;
    assign ready       = ready_q;
    assign fault       = fault_q;
    assign loss_count  = loss_q;
    assign retry_count = retry_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor: a phase/elapsed-time reference model
// predicts the outputs of every edge, a negedge monitor compares them.
module tb_pll_lock_supervisor;

    localparam int unsigned RSTC = 4;
    localparam int unsigned TO   = 20;
    localparam int unsigned ST   = 8;
    localparam int unsigned MR   = 2;
    localparam int unsigned CW   = 4;

    logic          sys_clk  = 1'b0;
    logic          rst      = 1'b1;
    logic          pll_lock = 1'b0;
    logic          pll_reset, core_rst, ready, fault;
    logic [CW-1:0] loss_count;
    logic [2:0]    retry_count;

    pll_lock_supervisor #(
        .RST_CYCLES   (RSTC),
        .LOCK_TIMEOUT (TO),
        .STABLE_CYCLES(ST),
        .MAX_RETRIES  (MR),
        .CNT_W        (CW)
    ) dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .pll_lock   (pll_lock),
        .pll_reset  (pll_reset),
        .core_rst   (core_rst),
        .ready      (ready),
        .fault      (fault),
        .loss_count (loss_count),
        .retry_count(retry_count)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic       pr;
        logic       cr;
        logic       rdy;
        logic       flt;
        logic [3:0] loss;
        logic [2:0] retry;
    } obs_t;

    typedef enum {P_PULSE, P_WAIT, P_SETTLE, P_LIVE, P_DEAD} phase_t;

    obs_t   exp_q[$];
    int     edge_q[$];
    int     tests = 0;
    int     fails = 0;

    phase_t ph = P_PULSE;
    int     since = 0;
    int     cyc = 0;
    int     loss_m = 0;
    int     retry_m = 0;
    int     pipe[$];

    function void enter(input phase_t p);
        ph    = p;
        since = cyc;
    endfunction

    // One sys_clk edge of the reference: lock is seen two edges after it is sampled.
    function void model_step(input logic r, input logic l);
        int ls;
        int age;
        cyc++;
        ls = pipe.pop_front();
        pipe.push_back(int'(l));
        age = cyc - since - 1;
        if (r) begin
            enter(P_PULSE);
            loss_m  = 0;
            retry_m = 0;
            pipe.delete();
            pipe.push_back(0);
            pipe.push_back(0);
        end else begin
            case (ph)
                P_PULSE:  if (age == int'(RSTC) - 1) enter(P_WAIT);
                P_WAIT: begin
                    if (ls != 0) enter(P_SETTLE);
                    else if (age == int'(TO) - 1) begin
                        retry_m++;
                        if (retry_m == int'(MR)) enter(P_DEAD);
                        else enter(P_PULSE);
                    end
                end
                P_SETTLE: begin
                    if (ls == 0) enter(P_WAIT);
                    else if (age == int'(ST) - 1) begin
                        enter(P_LIVE);
                        retry_m = 0;
                    end
                end
                P_LIVE: begin
                    if (ls == 0) begin
                        if (loss_m < 15) loss_m++;
                        enter(P_WAIT);
                    end
                end
                default: ;
            endcase
        end
    endfunction

    function obs_t model_out();
        obs_t o;
        o.pr    = (ph == P_PULSE) || (ph == P_DEAD);
        o.cr    = (ph != P_LIVE);
        o.rdy   = (ph == P_LIVE);
        o.flt   = (ph == P_DEAD);
        o.loss  = loss_m[3:0];
        o.retry = retry_m[2:0];
        return o;
    endfunction

    task automatic cycle(input logic r, input logic l);
        rst      = r;
        pll_lock = l;
        @(posedge sys_clk);
        model_step(r, l);
        exp_q.push_back(model_out());
        edge_q.push_back(cyc);
        #1;
    endtask

    task automatic dcheck(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    initial begin
        forever begin
            obs_t e;
            obs_t a;
            int   en;
            @(negedge sys_clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                en = edge_q.pop_front();
                a  = {pll_reset, core_rst, ready, fault, loss_count, retry_count};
                tests++;
                if (a !== e) begin
                    fails++;
                    $display("FAIL outputs edge %0d: got pr=%0b cr=%0b rdy=%0b flt=%0b loss=%0d retry=%0d, want pr=%0b cr=%0b rdy=%0b flt=%0b loss=%0d retry=%0d",
                             en, a.pr, a.cr, a.rdy, a.flt, a.loss, a.retry,
                             e.pr, e.cr, e.rdy, e.flt, e.loss, e.retry);
                end
            end
        end
    end

    initial begin
        int first;
        pipe.push_back(0);
        pipe.push_back(0);

        // Lock raised after edge 10 and held: release expected at edge 21.
        repeat (3) cycle(1'b1, 1'b0);
        first = -1;
        for (int e = 1; e <= 30; e++) begin
            cycle(1'b0, e >= 11);
            if (ready && first < 0) first = e;
        end
        dcheck("t1_release_edge", first, 21);
        dcheck("t1_fault", int'(fault), 0);

        // Lock dips low mid-settle (sampled low at edges 16,17): release moves to 28.
        cycle(1'b1, 1'b0);
        first = -1;
        for (int e = 1; e <= 40; e++) begin
            cycle(1'b0, (e >= 11) && !(e == 16 || e == 17));
            if (e == 21) dcheck("t2_core_rst_e21", int'(core_rst), 1);
            if (ready && first < 0) first = e;
        end
        dcheck("t2_release_edge", first, 28);
        dcheck("t2_loss", int'(loss_count), 0);

        // Sixteen 5-cycle losses in RUN: loss_count saturates at 15.
        for (int k = 0; k < 16; k++) begin
            for (int j = 1; j <= 5; j++) begin
                cycle(1'b0, 1'b0);
                if (k == 0 && j == 2) dcheck("t3_ready_before", int'(ready), 1);
                if (k == 0 && j == 3) dcheck("t3_core_rst_after3", int'(core_rst), 1);
            end
            for (int j = 1; j <= 15; j++) begin
                cycle(1'b0, 1'b1);
                if (k == 0 && j == 10) dcheck("t3_ready_j10", int'(ready), 0);
                if (k == 0 && j == 11) dcheck("t3_ready_j11", int'(ready), 1);
            end
        end
        dcheck("t3_loss_sat", int'(loss_count), 15);

        // No lock at all: two timeouts end in FAULT, which then ignores lock.
        cycle(1'b1, 1'b0);
        for (int e = 1; e <= 60; e++) cycle(1'b0, 1'b0);
        dcheck("t4_fault", int'(fault), 1);
        dcheck("t4_retry", int'(retry_count), 2);
        for (int e = 1; e <= 10; e++) cycle(1'b0, 1'b1);
        dcheck("t4_fault_sticky", int'(fault), 1);
        dcheck("t4_pll_reset", int'(pll_reset), 1);

        // One-cycle rst out of FAULT with lock already high: release at edge 13.
        cycle(1'b1, 1'b1);
        dcheck("t5_fault_cleared", int'(fault), 0);
        first = -1;
        for (int e = 1; e <= 20; e++) begin
            cycle(1'b0, 1'b1);
            if (ready && first < 0) first = e;
        end
        dcheck("t5_release_edge", first, 13);

        // One loss, then rst while in RUN.
        repeat (5) cycle(1'b0, 1'b0);
        repeat (15) cycle(1'b0, 1'b1);
        dcheck("t6_loss_pre", int'(loss_count), 1);
        cycle(1'b1, 1'b1);
        dcheck("t6_core_rst", int'(core_rst), 1);
        dcheck("t6_loss_cleared", int'(loss_count), 0);
        dcheck("t6_pll_reset", int'(pll_reset), 1);
        repeat (5) cycle(1'b0, 1'b1);

        // Random lock segments with occasional resets.
        for (int s = 0; s < 120; s++) begin
            logic lv;
            int   len;
            lv  = 1'($urandom_range(1));
            len = lv ? int'($urandom_range(40, 1)) : int'($urandom_range(60, 1));
            for (int j = 0; j < len; j++) begin
                cycle($urandom_range(149) == 0, lv);
            end
        end

        repeat (2) @(negedge sys_clk);
        #1;
        dcheck("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
